// File: rtl/gomoku_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// gomoku_game_ctrl_pkg : shared board geometry, codes and helpers
// Rev 1.0
// ============================================================================
package gomoku_game_ctrl_pkg;

   localparam int BOARD_N = 10;
   localparam int WIN_LEN = 5;
   localparam int CUR_W   = 4;
   localparam int CELLS   = BOARD_N * BOARD_N;

   localparam logic [1:0] c_win_none  = 2'b00;
   localparam logic [1:0] c_win_black = 2'b01;
   localparam logic [1:0] c_win_white = 2'b10;
   localparam logic [1:0] c_win_draw  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_DECIDE = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   // Line directions scanned by the win check: horizontal, vertical, diagonal, anti-diagonal
   localparam int c_dir_dr [4] = '{0, 1, 1, 1};
   localparam int c_dir_dc [4] = '{1, 0, 1, -1};

   function automatic int cell_idx(input int row, input int col);
      return row * BOARD_N + col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// btn_sync_edge : 2-FF synchronizer followed by a rising-edge pulse
// Rev 1.0
// ============================================================================
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign pulse = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/gomoku_game_ctrl.sv
`default_nettype none
// ============================================================================
// gomoku_game_ctrl : cursor, stone placement and sequential five-in-a-row check
// Rev 1.0
// ============================================================================
module gomoku_game_ctrl
   import gomoku_game_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn_up,
   input  logic                       btn_down,
   input  logic                       btn_left,
   input  logic                       btn_right,
   input  logic                       btn_place,
   input  logic                       btn_restart,
   output logic [BOARD_N*BOARD_N-1:0] board_black,
   output logic [BOARD_N*BOARD_N-1:0] board_white,
   output logic [CUR_W-1:0]           cursor_row,
   output logic [CUR_W-1:0]           cursor_col,
   output logic                       turn,
   output logic                       busy,
   output logic                       game_over,
   output logic [1:0]                 winner,
   output logic                       illegal,
   output logic [6:0]                 move_count
);

   localparam int c_b_right   = 0;
   localparam int c_b_left    = 1;
   localparam int c_b_down    = 2;
   localparam int c_b_up      = 3;
   localparam int c_b_place   = 4;
   localparam int c_b_restart = 5;

   logic [5:0] w_btn_raw;
   logic [5:0] w_pulse;

   assign w_btn_raw = {btn_restart, btn_place, btn_up, btn_down, btn_left, btn_right};

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         btn_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .btn   (w_btn_raw[gi]),
            .pulse (w_pulse[gi])
         );
      end
   endgenerate

   logic [CELLS-1:0] r_black, r_white;
   logic [CUR_W-1:0] r_row, r_col, r_pl_row, r_pl_col;
   logic             r_turn, r_busy, r_over, r_illegal, r_pl_white, r_alive, r_win;
   logic [1:0]       r_winner;
   logic [6:0]       r_count;
   logic [4:0]       r_probe;
   logic [3:0]       r_run;
   state_t           r_state;

   logic [1:0]       w_dir;
   int               w_dist, w_pr, w_pc;
   logic             w_inb, w_alive, w_hit, w_occ;
   logic [6:0]       w_pidx, w_cur_idx;
   logic [3:0]       w_run;
   logic [CUR_W-1:0] w_row_nxt, w_col_nxt;

   // Probe p: direction p[4:3], sense p[2] (1 = negative), distance p[1:0]+1
   always_comb begin
      w_dir     = r_probe[4:3];
      w_dist    = int'(r_probe[1:0]) + 1;
      if (r_probe[2]) w_dist = -w_dist;
      w_pr      = int'(r_pl_row) + w_dist * c_dir_dr[w_dir];
      w_pc      = int'(r_pl_col) + w_dist * c_dir_dc[w_dir];
      w_inb     = (w_pr >= 0) && (w_pr < BOARD_N) && (w_pc >= 0) && (w_pc < BOARD_N);
      w_pidx    = w_inb ? 7'(cell_idx(w_pr, w_pc)) : 7'd0;
      w_alive   = (r_probe[1:0] == 2'd0) ? 1'b1 : r_alive;
      w_hit     = w_alive && w_inb && (r_pl_white ? r_white[w_pidx] : r_black[w_pidx]);
      w_run     = r_run + {3'd0, w_hit};
      w_cur_idx = 7'(cell_idx(int'(r_row), int'(r_col)));
      w_occ     = r_black[w_cur_idx] | r_white[w_cur_idx];
   end

   always_comb begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
      if (w_pulse[c_b_up]) begin
         if (r_row != '0) w_row_nxt = r_row - CUR_W'(1);
      end else if (w_pulse[c_b_down]) begin
         if (r_row != CUR_W'(BOARD_N - 1)) w_row_nxt = r_row + CUR_W'(1);
      end else if (w_pulse[c_b_left]) begin
         if (r_col != '0) w_col_nxt = r_col - CUR_W'(1);
      end else if (w_pulse[c_b_right]) begin
         if (r_col != CUR_W'(BOARD_N - 1)) w_col_nxt = r_col + CUR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_black    <= '0;
         r_white    <= '0;
         r_row      <= CUR_W'(BOARD_N / 2);
         r_col      <= CUR_W'(BOARD_N / 2);
         r_turn     <= 1'b0;
         r_busy     <= 1'b0;
         r_over     <= 1'b0;
         r_winner   <= c_win_none;
         r_illegal  <= 1'b0;
         r_count    <= '0;
         r_state    <= ST_IDLE;
         r_probe    <= '0;
         r_run      <= '0;
         r_alive    <= 1'b0;
         r_win      <= 1'b0;
         r_pl_row   <= '0;
         r_pl_col   <= '0;
         r_pl_white <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         if (w_pulse[c_b_restart]) begin
            // New game: cursor deliberately keeps its position
            r_black  <= '0;
            r_white  <= '0;
            r_turn   <= 1'b0;
            r_busy   <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= c_win_none;
            r_count  <= '0;
            r_state  <= ST_IDLE;
            r_win    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_pulse[c_b_place]) begin
                     if (w_occ) begin
                        r_illegal <= 1'b1;
                     end else begin
                        if (r_turn) r_white[w_cur_idx] <= 1'b1;
                        else        r_black[w_cur_idx] <= 1'b1;
                        r_count    <= r_count + 7'd1;
                        r_pl_row   <= r_row;
                        r_pl_col   <= r_col;
                        r_pl_white <= r_turn;
                        r_busy     <= 1'b1;
                        r_probe    <= '0;
                        r_run      <= '0;
                        r_win      <= 1'b0;
                        r_state    <= ST_CHECK;
                     end
                  end else begin
                     r_row <= w_row_nxt;
                     r_col <= w_col_nxt;
                  end
               end
               ST_CHECK: begin
                  r_alive <= w_hit;
                  r_run   <= w_run;
                  if (r_probe[2:0] == 3'd7) begin
                     r_run <= '0;
                     if (int'(w_run) + 1 >= WIN_LEN) r_win <= 1'b1;
                  end
                  r_probe <= r_probe + 5'd1;
                  if (r_probe == 5'd31) r_state <= ST_DECIDE;
               end
               ST_DECIDE: begin
                  r_busy <= 1'b0;
                  if (r_win) begin
                     r_over   <= 1'b1;
                     r_winner <= r_pl_white ? c_win_white : c_win_black;
                     r_state  <= ST_OVER;
                  end else if (r_count == 7'(CELLS)) begin
                     r_over   <= 1'b1;
                     r_winner <= c_win_draw;
                     r_state  <= ST_OVER;
                  end else begin
                     r_turn  <= ~r_turn;
                     r_state <= ST_IDLE;
                  end
               end
               ST_OVER: begin
                  if (!w_pulse[c_b_place]) begin
                     r_row <= w_row_nxt;
                     r_col <= w_col_nxt;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign board_black = r_black;
   assign board_white = r_white;
   assign cursor_row  = r_row;
   assign cursor_col  = r_col;
   assign turn        = r_turn;
   assign busy        = r_busy;
   assign game_over   = r_over;
   assign winner      = r_winner;
   assign illegal     = r_illegal;
   assign move_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gomoku_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gomoku_game_ctrl : directed vector bench for gomoku_game_ctrl
// Rev 1.0
// ============================================================================
module tb_gomoku_game_ctrl;
   import gomoku_game_ctrl_pkg::*;

   localparam int A_UP = 0, A_DOWN = 1, A_LEFT = 2, A_RIGHT = 3, A_PLACE = 4, A_RST = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_place = 0, btn_restart = 0;
   logic [BOARD_N*BOARD_N-1:0] board_black, board_white;
   logic [CUR_W-1:0]           cursor_row, cursor_col;
   logic                       turn, busy, game_over, illegal;
   logic [1:0]                 winner;
   logic [6:0]                 move_count;

   gomoku_game_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_place   (btn_place),
      .btn_restart (btn_restart),
      .board_black (board_black),
      .board_white (board_white),
      .cursor_row  (cursor_row),
      .cursor_col  (cursor_col),
      .turn        (turn),
      .busy        (busy),
      .game_over   (game_over),
      .winner      (winner),
      .illegal     (illegal),
      .move_count  (move_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int act; int row; int col;
      int turn; int mc; int over; int win;
      int ill; int busy; int blk; int wht;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_row   = 5;
   int   m_col   = 5;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input int act, row, col, t, mc, ov, w, ill, bz, blk, wht);
      vec_t v;
      v.act = act; v.row = row; v.col = col; v.turn = t; v.mc = mc; v.over = ov;
      v.win = w; v.ill = ill; v.busy = bz; v.blk = blk; v.wht = wht;
      vecs.push_back(v);
   endfunction

   function automatic void mv(input int act, row, col);
      add(act, row, col, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Legal placement; colour 1 = black stone, 2 = white stone
   function automatic void pl(input int row, col, t, mc, ov, w, colour);
      add(A_PLACE, row, col, t, mc, ov, w, 0, 33, int'(colour == 1), int'(colour == 2));
   endfunction

   task automatic set_btn(input int b, input logic v);
      case (b)
         A_UP:    btn_up      = v;
         A_DOWN:  btn_down    = v;
         A_LEFT:  btn_left    = v;
         A_RIGHT: btn_right   = v;
         A_PLACE: btn_place   = v;
         default: btn_restart = v;
      endcase
   endtask

   // Returns 1ns after the edge on which the action becomes visible; button left high
   task automatic press(input int b);
      repeat (3) @(posedge clk);
      @(negedge clk);
      set_btn(b, 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic tap(input int b);
      press(b);
      set_btn(b, 1'b0);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto(input int r, input int c);
      while (m_row > r) begin tap(A_UP);    m_row--; end
      while (m_row < r) begin tap(A_DOWN);  m_row++; end
      while (m_col > c) begin tap(A_LEFT);  m_col--; end
      while (m_col < c) begin tap(A_RIGHT); m_col++; end
   endtask

   initial begin
      vec_t v;
      int   nb;
      int   ill;
      int   idx;

      // Cursor walk with saturation at both edges
      mv(A_RIGHT, 5, 6); mv(A_RIGHT, 5, 7); mv(A_RIGHT, 5, 8);
      mv(A_RIGHT, 5, 9); mv(A_RIGHT, 5, 9); mv(A_RIGHT, 5, 9);
      mv(A_DOWN, 6, 9); mv(A_DOWN, 7, 9); mv(A_DOWN, 8, 9); mv(A_DOWN, 9, 9);
      mv(A_DOWN, 9, 9); mv(A_DOWN, 9, 9); mv(A_DOWN, 9, 9);
      mv(A_LEFT, 9, 8); mv(A_LEFT, 9, 7); mv(A_LEFT, 9, 6); mv(A_LEFT, 9, 5);
      mv(A_LEFT, 9, 4); mv(A_LEFT, 9, 3); mv(A_LEFT, 9, 2); mv(A_LEFT, 9, 1);
      mv(A_LEFT, 9, 0); mv(A_LEFT, 9, 0);
      mv(A_UP, 8, 0);
      // First stone, then an illegal re-place on the same cell
      pl(5, 5, 1, 1, 0, 0, 1);
      add(A_PLACE, 5, 5, 1, 1, 0, 0, 1, 0, 1, 0);
      add(A_RST, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      // Diagonal win completed in the middle
      pl(2, 2, 1, 1, 0, 0, 1); pl(0, 9, 0, 2, 0, 0, 2);
      pl(3, 3, 1, 3, 0, 0, 1); pl(1, 9, 0, 4, 0, 0, 2);
      pl(4, 4, 1, 5, 0, 0, 1); pl(2, 9, 0, 6, 0, 0, 2);
      pl(6, 6, 1, 7, 0, 0, 1); pl(3, 9, 0, 8, 0, 0, 2);
      pl(5, 5, 0, 9, 1, 1, 1);
      add(A_PLACE, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
      add(A_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Horizontal win along row 0
      pl(0, 0, 1, 1, 0, 0, 1); pl(9, 0, 0, 2, 0, 0, 2);
      pl(0, 1, 1, 3, 0, 0, 1); pl(9, 1, 0, 4, 0, 0, 2);
      pl(0, 2, 1, 5, 0, 0, 1); pl(9, 2, 0, 6, 0, 0, 2);
      pl(0, 3, 1, 7, 0, 0, 1); pl(9, 3, 0, 8, 0, 0, 2);
      pl(0, 4, 0, 9, 1, 1, 1);
      add(A_RST, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      // Row-wrap must not count, then white wins through the col -1 edge
      pl(0, 7, 1, 1, 0, 0, 1); pl(9, 0, 0, 2, 0, 0, 2);
      pl(0, 8, 1, 3, 0, 0, 1); pl(9, 2, 0, 4, 0, 0, 2);
      pl(0, 9, 1, 5, 0, 0, 1); pl(9, 4, 0, 6, 0, 0, 2);
      pl(1, 0, 1, 7, 0, 0, 1); pl(9, 6, 0, 8, 0, 0, 2);
      pl(1, 1, 1, 9, 0, 0, 1);
      pl(9, 1, 0, 10, 0, 0, 2); pl(5, 5, 1, 11, 0, 0, 1);
      pl(9, 3, 1, 12, 1, 2, 2);
      add(A_RST, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_row", int'(cursor_row), 5);
      check("rst_col", int'(cursor_col), 5);
      check("rst_boards", int'(|board_black) + int'(|board_white), 0);
      check("rst_status", int'({turn, busy, game_over, winner, illegal}), 0);
      check("rst_count", int'(move_count), 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         v = vecs[i];
         if (v.act == A_PLACE) goto(v.row, v.col);
         press(v.act);
         ill = int'(illegal);
         wait_idle(nb);
         set_btn(v.act, 1'b0);
         if (v.act != A_PLACE && v.act != A_RST) begin
            m_row = v.row;
            m_col = v.col;
         end
         idx = v.row * BOARD_N + v.col;
         check($sformatf("v%0d_row", i), int'(cursor_row), v.row);
         check($sformatf("v%0d_col", i), int'(cursor_col), v.col);
         check($sformatf("v%0d_turn", i), int'(turn), v.turn);
         check($sformatf("v%0d_count", i), int'(move_count), v.mc);
         check($sformatf("v%0d_over", i), int'(game_over), v.over);
         check($sformatf("v%0d_winner", i), int'(winner), v.win);
         check($sformatf("v%0d_illegal", i), ill, v.ill);
         check($sformatf("v%0d_busy_cycles", i), nb, v.busy);
         check($sformatf("v%0d_black_bit", i), int'(board_black[idx]), v.blk);
         check($sformatf("v%0d_white_bit", i), int'(board_white[idx]), v.wht);
      end

      // Restart lands on E+10 of a running check
      goto(4, 4);
      press(A_PLACE);
      set_btn(A_PLACE, 1'b0);
      check("mid_busy_start", int'(busy), 1);
      repeat (4) @(posedge clk);
      #1;
      press(A_RST);
      set_btn(A_RST, 1'b0);
      check("mid_busy_cleared", int'(busy), 0);
      check("mid_boards", int'(|board_black) + int'(|board_white), 0);
      check("mid_count", int'(move_count), 0);
      check("mid_turn", int'(turn), 0);
      check("mid_cursor", int'(cursor_row) * 16 + int'(cursor_col), 4 * 16 + 4);
      press(A_PLACE);
      wait_idle(nb);
      set_btn(A_PLACE, 1'b0);
      check("mid_replace_busy", nb, 33);
      check("mid_replace_black", int'(board_black[44]), 1);
      check("mid_replace_turn", int'(turn), 1);

      // Asynchronous reset mid-check, sampled away from any edge
      goto(3, 3);
      press(A_PLACE);
      set_btn(A_PLACE, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_row", int'(cursor_row), 5);
      check("arst_col", int'(cursor_col), 5);
      check("arst_busy", int'(busy), 0);
      check("arst_boards", int'(|board_black) + int'(|board_white), 0);
      check("arst_status", int'({turn, game_over, winner, illegal}), 0);
      check("arst_count", int'(move_count), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
